calc1_port_responder: RTL

- Synthesizable responder for one calc1 request port: the answering end of the cmd/data protocol that the calc1 driver initiates.
- Accepts a command with operand1, then operand2 on the following cycle.
- Computes add/sub/shift-left/shift-right and returns a one-cycle response code with result data after a fixed latency.
- Four instances form a behavioural calc1 port array usable as a second reference or as a stand-in DUV.

---
 rtl/calc1_pkg.sv | 29 ++
 rtl/calc1_port_responder_if.sv | 30 +++
 rtl/calc1_alu.sv | 44 ++++
 rtl/calc1_port_responder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared constants and types for the calc1 port responder.
//   - command codes carried on req_cmd_in
//   - response codes driven on out_resp
//   - responder state encoding
//   - shift-amount width (only op2[SHAMT_W-1:0] is used by the shifts)
package calc1_pkg;

   localparam int CMD_W   = 4;
   localparam int RESP_W  = 2;
   localparam int SHAMT_W = 5;

   localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
   localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
   localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

   localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
   localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
   localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      OP2,
      EXEC,
      RESP
   } state_t;

endpackage

// File: rtl/calc1_port_responder_if.sv
// calc1_port_responder_if: one calc1 request port.
//   req_cmd_in   master->slave  command code (CMD_W bits)
//   req_data_in  master->slave  operand1 in the command cycle, operand2 the next cycle
//   out_resp     slave->master  response code, one cycle wide
//   out_data     slave->master  result, nonzero only alongside RESP_OK
// master modport: the calc1 driver; slave modport: the responder.
interface calc1_port_responder_if
   import calc1_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic [CMD_W-1:0]  req_cmd_in;
   logic [DATA_W-1:0] req_data_in;
   logic [RESP_W-1:0] out_resp;
   logic [DATA_W-1:0] out_data;

   modport master (
      output req_cmd_in,
      output req_data_in,
      input  out_resp,
      input  out_data
   );

   modport slave (
      input  req_cmd_in,
      input  req_data_in,
      output out_resp,
      output out_data
   );
endinterface

// File: rtl/calc1_alu.sv
// calc1_alu: purely combinational calc1 arithmetic, all unsigned.
//   cmd     command code (latched by the responder)
//   op1     first operand
//   op2     second operand; shifts use only op2[SHAMT_W-1:0]
//   result  arithmetic result, forced to 0 whenever err is set
//   err     add carry-out, sub underflow, or unsupported command
module calc1_alu
   import calc1_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic [CMD_W-1:0]  cmd,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   logic [DATA_W:0]    sum;
   logic [SHAMT_W-1:0] shamt;

   assign sum   = {1'b0, op1} + {1'b0, op2};
   assign shamt = op2[SHAMT_W-1:0];

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (cmd)
         CMD_ADD: begin
            if (sum[DATA_W]) err    = 1'b1;
            else             result = sum[DATA_W-1:0];
         end
         CMD_SUB: begin
            if (op2 > op1) err    = 1'b1;
            else           result = op1 - op2;
         end
         CMD_SHL: result = op1 << shamt;
         CMD_SHR: result = op1 >> shamt;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1_port_responder: answering end of one calc1 request port.
// Accepts cmd+operand1, then operand2 on the next cycle, and returns a
// one-cycle registered response LATENCY cycles after the operand2 cycle.
// Single outstanding transaction; commands arriving while busy are dropped.
//
// Ports:
//   c_clk     rising-edge clock
//   reset     synchronous, active-high
//   busy_out  (only with CALC1_BUSY_OUT_EN) high while in OP2, EXEC or RESP
//   port_if   calc1_port_responder_if.slave (cmd/data in, resp/data out)
// Parameters:
//   LATENCY   1..15, operand2 cycle to response cycle
//   DATA_W    operand/result width
// Optional feature macro: CALC1_BUSY_OUT_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a nonzero command; latches cmd and operand1
// OP2   | latches operand2, loads the latency down-counter
// EXEC  | counter running; result registered when it reaches zero
// RESP  | response visible for this single cycle, then back to IDLE
module calc1_port_responder
   import calc1_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int DATA_W  = 32
)
(
   input  logic c_clk,
   input  logic reset,
`ifdef CALC1_BUSY_OUT_EN
   output logic busy_out,
`endif
   calc1_port_responder_if.slave port_if
);

   // Loaded on the OP2 edge; the result is registered on the EXEC edge
   // that takes the counter to zero, which puts the response in cycle
   // operand2 + LATENCY. LATENCY==1 skips EXEC entirely.
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t             state, state_nx;
   logic [3:0]         cnt, cnt_nx;
   logic [CMD_W-1:0]   cmd_q, cmd_nx;
   logic [DATA_W-1:0]  op1_q, op1_nx;
   logic [DATA_W-1:0]  op2_q, op2_nx;
   logic [RESP_W-1:0]  resp_q, resp_nx;
   logic [DATA_W-1:0]  data_q, data_nx;

   logic [DATA_W-1:0]  alu_op2;
   logic [DATA_W-1:0]  alu_result;
   logic               alu_err;
   logic [RESP_W-1:0]  done_resp;
   logic [DATA_W-1:0]  done_data;

   // In OP2 operand2 is still on the bus; feeding it straight through lets
   // a LATENCY of 1 register the result on the operand2 edge.
   assign alu_op2 = (state == OP2) ? port_if.req_data_in : op2_q;

   calc1_alu #(.DATA_W(DATA_W)) u_alu (
      .cmd    (cmd_q),
      .op1    (op1_q),
      .op2    (alu_op2),
      .result (alu_result),
      .err    (alu_err)
   );

   assign done_resp = alu_err ? RESP_ERR : RESP_OK;
   assign done_data = alu_err ? '0 : alu_result;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cmd_nx   = cmd_q;
      op1_nx   = op1_q;
      op2_nx   = op2_q;
      resp_nx  = RESP_NONE;
      data_nx  = '0;
      case (state)
         IDLE: begin
            if (port_if.req_cmd_in != CMD_NOP) begin
               cmd_nx   = port_if.req_cmd_in;
               op1_nx   = port_if.req_data_in;
               state_nx = OP2;
            end
         end
         OP2: begin
            op2_nx = port_if.req_data_in;
            cnt_nx = CNT_LOAD;
            if (CNT_LOAD == 4'd0) begin
               resp_nx  = done_resp;
               data_nx  = done_data;
               state_nx = RESP;
            end else begin
               state_nx = EXEC;
            end
         end
         EXEC: begin
            if (cnt <= 4'd1) begin
               cnt_nx   = 4'd0;
               resp_nx  = done_resp;
               data_nx  = done_data;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         cmd_q  <= CMD_NOP;
         op1_q  <= '0;
         op2_q  <= '0;
         resp_q <= RESP_NONE;
         data_q <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         cmd_q  <= cmd_nx;
         op1_q  <= op1_nx;
         op2_q  <= op2_nx;
         resp_q <= resp_nx;
         data_q <= data_nx;
      end
   end

   assign port_if.out_resp = resp_q;
   assign port_if.out_data = data_q;

`ifdef CALC1_BUSY_OUT_EN
   logic busy_q;

   always_ff @(posedge c_clk) begin
      if (reset) busy_q <= 1'b0;
      else       busy_q <= (state_nx != IDLE);
   end

   assign busy_out = busy_q;
`endif

endmodule
